// File: rtl/canvas_scan_if.sv
// rtl/canvas_scan_if.sv - camera, generator and ray handshake signals of canvas_scan
interface canvas_scan_if;
  logic        start;
  logic [30:0] normal_in;
  logic [7:0]  dist_in;
  logic [30:0] view_normal;
  logic [7:0]  view_dist;
  logic [12:0] view_loc;
  logic [30:0] view_out;
  logic        ray_valid;
  logic        ray_ready;
  logic [30:0] ray_data;
  logic [12:0] ray_loc;
  logic        ray_last;
  logic        busy;
  logic        frame_done;

  modport slave (
    input  start, normal_in, dist_in, view_out, ray_ready,
    output view_normal, view_dist, view_loc, ray_valid, ray_data, ray_loc,
           ray_last, busy, frame_done
  );

  modport master (
    output start, normal_in, dist_in, view_out, ray_ready,
    input  view_normal, view_dist, view_loc, ray_valid, ray_data, ray_loc,
           ray_last, busy, frame_done
  );
endinterface

// File: rtl/canvas_scan.sv
// rtl/canvas_scan.sv - raster-order ray dispatcher between view-ray generator and tracer
// Optional abort input enabled by defining CANVAS_SCAN_ABORT_EN.
module canvas_scan #(
  parameter int X_LAST = 127,
  parameter int Y_LAST = 63,
  parameter int SETTLE = 3
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CANVAS_SCAN_ABORT_EN
  input  logic abort,
`endif
  canvas_scan_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE_ST, HOLD, DONE} state_t;

  localparam logic [6:0] XL        = 7'(X_LAST);
  localparam logic [5:0] YL        = 6'(Y_LAST);
  // The first window is one cycle longer: the freshly latched camera must reach
  // the generator as well as the first location.
  localparam logic [3:0] CNT_FIRST = 4'(SETTLE);
  localparam logic [3:0] CNT_NEXT  = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic [30:0] normal_q, normal_d;
  logic [7:0]  dist_q, dist_d;
  logic [30:0] data_q, data_d;
  logic [12:0] loc_q, loc_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        abort_w;

`ifdef CANVAS_SCAN_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    normal_d = normal_q;
    dist_d   = dist_q;
    data_d   = data_q;
    loc_d    = loc_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          normal_d = bus.normal_in;
          dist_d   = bus.dist_in;
          x_d      = '0;
          y_d      = '0;
          cnt_d    = CNT_FIRST;
          state_d  = SETTLE_ST;
        end
      end
      SETTLE_ST: begin
        if (cnt_q == 4'd0) begin
          data_d  = bus.view_out;
          loc_d   = {x_q, y_q};
          last_d  = (x_q == XL) && (y_q == YL);
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (bus.ray_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = DONE;
          end else begin
            if (x_q == XL) begin
              x_d = '0;
              y_d = y_q + 6'd1;
            end else begin
              x_d = x_q + 7'd1;
            end
            cnt_d   = CNT_NEXT;
            state_d = SETTLE_ST;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort leaves the camera and the current location untouched.
    if (abort_w && state_q != IDLE) begin
      state_d = IDLE;
      x_d     = x_q;
      y_d     = y_q;
      valid_d = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      normal_q <= '0;
      dist_q   <= '0;
      data_q   <= '0;
      loc_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      normal_q <= normal_d;
      dist_q   <= dist_d;
      data_q   <= data_d;
      loc_q    <= loc_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.view_normal = normal_q;
  assign bus.view_dist   = dist_q;
  assign bus.view_loc    = {x_q, y_q};
  assign bus.ray_valid   = valid_q;
  assign bus.ray_data    = data_q;
  assign bus.ray_loc     = loc_q;
  assign bus.ray_last    = last_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;

endmodule
